// File: rtl/trigger_source_arbiter_if.sv
// Trigger arbiter bundle: source requests and controls in, grant pulse and status out.
// slave = arbiter side, master = trigger-source / control side.
interface trigger_source_arbiter_if #(
    parameter int NUM_SRC   = 4,
    parameter int HOLDOFF_W = 8,
    parameter int CNT_W     = 16
);
    logic [NUM_SRC-1:0]   req_i;
    logic [NUM_SRC-1:0]   src_en_i;
    logic [HOLDOFF_W-1:0] holdoff_i;
    logic                 dead_i;
    logic                 clr_drop_i;
    logic                 grant_o;
    logic [NUM_SRC-1:0]   grant_src_o;
    logic [NUM_SRC-1:0]   pending_o;
    logic                 busy_o;
    logic [CNT_W-1:0]     drop_count_o;

    modport master (
        output req_i, src_en_i, holdoff_i, dead_i, clr_drop_i,
        input  grant_o, grant_src_o, pending_o, busy_o, drop_count_o
    );

    modport slave (
        input  req_i, src_en_i, holdoff_i, dead_i, clr_drop_i,
        output grant_o, grant_src_o, pending_o, busy_o, drop_count_o
    );
endinterface

// File: rtl/trigger_source_arbiter.sv
// Latches rising-edge trigger requests and grants them one at a time with holdoff and dead blocking.
// Define TRIG_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index priority.
module trigger_source_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int HOLDOFF_W = 8,
    parameter int CNT_W     = 16
) (
    input  logic                   clk250_i,
    input  logic                   rst_n_i,
    trigger_source_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [HOLDOFF_W-1:0] HOLD_ONE = {{(HOLDOFF_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_SRC-1:0]   SRC_ONE  = {{(NUM_SRC-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_HOLDOFF = 1'b1
    } state_t;

    state_t               state_r;
    logic [NUM_SRC-1:0]   req_q_r;
    logic [NUM_SRC-1:0]   pending_r;
    logic                 grant_r;
    logic [NUM_SRC-1:0]   grant_src_r;
    logic                 busy_r;
    logic [HOLDOFF_W-1:0] hold_cnt_r;
    logic [CNT_W-1:0]     drop_cnt_r;

    logic [NUM_SRC-1:0]   req_edge_s;
    logic [NUM_SRC-1:0]   eligible_s;
    logic                 win_valid_s;
    logic [IDX_W-1:0]     win_idx_s;
    logic [NUM_SRC-1:0]   win_onehot_s;
    logic [NUM_SRC-1:0]   grant_now_s;
    logic [NUM_SRC-1:0]   drop_vec_s;
    logic [NUM_SRC-1:0]   pending_next_s;
    logic [CNT_W:0]       drop_sum_s;
    logic [CNT_W-1:0]     drop_next_s;

    function automatic logic [CNT_W:0] popcount(input logic [NUM_SRC-1:0] v);
        logic [CNT_W:0]     n;
        logic [NUM_SRC-1:0] sh;
        n = {(CNT_W+1){1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            sh = v >> i;
            n  = n + {{CNT_W{1'b0}}, sh[0]};
        end
        return n;
    endfunction

`ifdef TRIG_ARB_ROUND_ROBIN_EN
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_SRC - 1);

    logic [IDX_W-1:0] last_winner_r;

    // First eligible source at or after the one following the previous winner.
    function automatic logic [IDX_W-1:0] pick_rr(input logic [NUM_SRC-1:0] elig,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0]   win;
        logic               found;
        logic [NUM_SRC-1:0] sh;
        int                 idx;
        win   = {IDX_W{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = (int'(last) + 1 + i) % NUM_SRC;
            sh  = elig >> idx;
            if (!found && sh[0]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction
`else
    function automatic logic [IDX_W-1:0] pick_fixed(input logic [NUM_SRC-1:0] elig);
        logic [IDX_W-1:0]   win;
        logic [NUM_SRC-1:0] sh;
        win = {IDX_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            sh = elig >> i;
            if (sh[0]) begin
                win = IDX_W'(i);
            end else begin
                win = win;
            end
        end
        return win;
    endfunction
`endif

    // Edge detection, eligibility and winner selection for the current cycle.
    always_comb begin
        req_edge_s  = bus.req_i & ~req_q_r & bus.src_en_i;
        eligible_s  = pending_r & bus.src_en_i;
`ifdef TRIG_ARB_ROUND_ROBIN_EN
        win_idx_s   = pick_rr(eligible_s, last_winner_r);
`else
        win_idx_s   = pick_fixed(eligible_s);
`endif
        win_onehot_s = SRC_ONE << win_idx_s;
        if ((state_r == ST_IDLE) && (eligible_s != {NUM_SRC{1'b0}}) && !bus.dead_i) begin
            win_valid_s = 1'b1;
        end else begin
            win_valid_s = 1'b0;
        end
        if (win_valid_s) begin
            grant_now_s = win_onehot_s;
        end else begin
            grant_now_s = {NUM_SRC{1'b0}};
        end
    end

    // Pending update and saturating drop accounting; a re-edge on the granted source is re-latched, not dropped.
    always_comb begin
        pending_next_s = bus.src_en_i & ((pending_r & ~grant_now_s) | req_edge_s);
        drop_vec_s     = req_edge_s & pending_r & ~grant_now_s;
        drop_sum_s     = {1'b0, drop_cnt_r} + popcount(drop_vec_s);
        if (bus.clr_drop_i) begin
            drop_next_s = {CNT_W{1'b0}};
        end else if (drop_sum_s[CNT_W]) begin
            drop_next_s = {CNT_W{1'b1}};
        end else begin
            drop_next_s = drop_sum_s[CNT_W-1:0];
        end
    end

    // Request history, pending bits and drop counter.
    always_ff @(posedge clk250_i) begin
        if (!rst_n_i) begin
            req_q_r    <= {NUM_SRC{1'b0}};
            pending_r  <= {NUM_SRC{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            req_q_r    <= bus.req_i;
            pending_r  <= pending_next_s;
            drop_cnt_r <= drop_next_s;
        end
    end

    // Grant/holdoff state machine with registered grant, source and busy outputs.
    always_ff @(posedge clk250_i) begin
        if (!rst_n_i) begin
            state_r       <= ST_IDLE;
            grant_r       <= 1'b0;
            grant_src_r   <= {NUM_SRC{1'b0}};
            busy_r        <= 1'b0;
            hold_cnt_r    <= {HOLDOFF_W{1'b0}};
`ifdef TRIG_ARB_ROUND_ROBIN_EN
            last_winner_r <= LAST_INIT;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        state_r       <= ST_HOLDOFF;
                        grant_r       <= 1'b1;
                        grant_src_r   <= win_onehot_s;
                        busy_r        <= 1'b1;
                        hold_cnt_r    <= bus.holdoff_i;
`ifdef TRIG_ARB_ROUND_ROBIN_EN
                        last_winner_r <= win_idx_s;
`endif
                    end else begin
                        grant_r       <= 1'b0;
                        grant_src_r   <= {NUM_SRC{1'b0}};
                        busy_r        <= 1'b0;
                    end
                end
                ST_HOLDOFF: begin
                    grant_r     <= 1'b0;
                    grant_src_r <= {NUM_SRC{1'b0}};
                    if (hold_cnt_r == {HOLDOFF_W{1'b0}}) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - HOLD_ONE;
                        busy_r     <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    grant_r     <= 1'b0;
                    grant_src_r <= {NUM_SRC{1'b0}};
                    busy_r      <= 1'b0;
                    hold_cnt_r  <= {HOLDOFF_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.grant_o      = grant_r;
    assign bus.grant_src_o  = grant_src_r;
    assign bus.pending_o    = pending_r;
    assign bus.busy_o       = busy_r;
    assign bus.drop_count_o = drop_cnt_r;

endmodule

// File: tb/tb_trigger_source_arbiter.sv
// Directed bench for trigger_source_arbiter: a time-based reference model checked every cycle,
// plus literal expectations at the key cycles of each scenario.
module tb_trigger_source_arbiter;

    localparam int NUM_SRC   = 4;
    localparam int HOLDOFF_W = 8;
    localparam int CNT_W     = 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    trigger_source_arbiter_if #(.NUM_SRC(NUM_SRC), .HOLDOFF_W(HOLDOFF_W), .CNT_W(CNT_W)) bus ();

    trigger_source_arbiter #(.NUM_SRC(NUM_SRC), .HOLDOFF_W(HOLDOFF_W), .CNT_W(CNT_W)) dut (
        .clk250_i (clk),
        .rst_n_i  (rst_n),
        .bus      (bus.slave)
    );

    always #2 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: idle is "current cycle at or past the free time of the last grant".
    logic               m_valid = 1'b0;
    logic [NUM_SRC-1:0] m_pend, m_req_q, m_gsrc;
    logic               m_grant, m_busy;
    int                 m_drop, m_free_at, m_last, m_win, m_drops, m_sel;
    logic               m_e;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid   = 1'b1;
            m_pend    = '0;
            m_req_q   = '0;
            m_gsrc    = '0;
            m_grant   = 1'b0;
            m_busy    = 1'b0;
            m_drop    = 0;
            m_free_at = 0;
            m_last    = NUM_SRC - 1;
        end else if (m_valid) begin
            m_win = -1;
            if (cyc >= m_free_at && !bus.dead_i) begin
                for (int k = 0; k < NUM_SRC; k++) begin
`ifdef TRIG_ARB_ROUND_ROBIN_EN
                    m_sel = (m_last + 1 + k) % NUM_SRC;
`else
                    m_sel = k;
`endif
                    if (m_win < 0 && m_pend[m_sel] && bus.src_en_i[m_sel]) m_win = m_sel;
                end
            end
            m_drops = 0;
            for (int s = 0; s < NUM_SRC; s++) begin
                m_e = bus.req_i[s] && !m_req_q[s] && bus.src_en_i[s];
                if (m_e && m_pend[s] && s != m_win) m_drops++;
                if (!bus.src_en_i[s])  m_pend[s] = 1'b0;
                else if (s == m_win)   m_pend[s] = m_e;
                else                   m_pend[s] = m_pend[s] | m_e;
            end
            if (bus.clr_drop_i) m_drop = 0;
            else                m_drop = (m_drop + m_drops > CNT_MAX) ? CNT_MAX : m_drop + m_drops;
            m_grant = (m_win >= 0);
            m_gsrc  = (m_win >= 0) ? NUM_SRC'(1 << m_win) : '0;
            if (m_win >= 0) begin
                m_free_at = cyc + 2 + int'(bus.holdoff_i);
                m_last    = m_win;
            end
            m_busy  = (cyc + 1) < m_free_at;
            m_req_q = bus.req_i;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_grant",     32'(bus.grant_o),      32'(m_grant));
            check("m_grant_src", 32'(bus.grant_src_o),  32'(m_gsrc));
            check("m_pending",   32'(bus.pending_o),    32'(m_pend));
            check("m_busy",      32'(bus.busy_o),       32'(m_busy));
            check("m_drop",      32'(bus.drop_count_o), 32'(m_drop));
        end
    end

    logic [NUM_SRC-1:0] exp1 [4];
    logic [NUM_SRC-1:0] exp2 [4];

    initial begin
        exp1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`ifdef TRIG_ARB_ROUND_ROBIN_EN
        exp2 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        exp2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
        rst_n          = 1'b0;
        bus.req_i      = 4'b0000;
        bus.src_en_i   = 4'b1111;
        bus.holdoff_i  = 8'd4;
        bus.dead_i     = 1'b0;
        bus.clr_drop_i = 1'b0;
        tick(3);
        check("rst_grant",   32'(bus.grant_o), 32'd0);
        check("rst_src",     32'(bus.grant_src_o), 32'd0);
        check("rst_pending", 32'(bus.pending_o), 32'd0);
        check("rst_busy",    32'(bus.busy_o), 32'd0);
        check("rst_drop",    32'(bus.drop_count_o), 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Single RF request, holdoff 4.
        bus.req_i = 4'b0001;
        tick(1);
        check("t1_pending", 32'(bus.pending_o), 32'h1);
        check("t1_nogrant", 32'(bus.grant_o), 32'd0);
        bus.req_i = 4'b0000;
        tick(1);
        check("t1_grant", 32'(bus.grant_o), 32'd1);
        check("t1_src",   32'(bus.grant_src_o), 32'h1);
        check("t1_busy",  32'(bus.busy_o), 32'd1);
        check("t1_clear", 32'(bus.pending_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("t1_hold_busy",  32'(bus.busy_o), 32'd1);
            check("t1_hold_grant", 32'(bus.grant_o), 32'd0);
        end
        tick(1);
        check("t1_idle", 32'(bus.busy_o), 32'd0);

        // Simultaneous requests, holdoff 0.
        bus.holdoff_i = 8'd0;
        tick(2);
        bus.req_i = 4'b1111;
        tick(1);
        bus.req_i = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("t2_grant", 32'(bus.grant_o), 32'd1);
            check("t2_src",   32'(bus.grant_src_o), 32'(exp1[k]));
            tick(1);
            check("t2_gap",   32'(bus.grant_o), 32'd0);
        end
        check("t2_nodrop", 32'(bus.drop_count_o), 32'd0);

        // RF alone, then a second burst.
        bus.req_i = 4'b0001;
        tick(1);
        bus.req_i = 4'b0000;
        tick(1);
        check("t2b_rf", 32'(bus.grant_src_o), 32'h1);
        tick(1);
        bus.req_i = 4'b1111;
        tick(1);
        bus.req_i = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("t2b_grant", 32'(bus.grant_o), 32'd1);
            check("t2b_src",   32'(bus.grant_src_o), 32'(exp2[k]));
            tick(1);
        end

        // Dead blocking.
        bus.holdoff_i = 8'd2;
        tick(2);
        bus.dead_i = 1'b1;
        bus.req_i  = 4'b0100;
        tick(1);
        bus.req_i  = 4'b0000;
        check("t3_pending", 32'(bus.pending_o), 32'h4);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("t3_blocked", 32'(bus.grant_o), 32'd0);
            check("t3_held",    32'(bus.pending_o), 32'h4);
        end
        bus.dead_i = 1'b0;
        tick(1);
        check("t3_grant", 32'(bus.grant_o), 32'd1);
        check("t3_src",   32'(bus.grant_src_o), 32'h4);
        tick(4);

        // Drop counting, clear priority and saturation.
        bus.dead_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.req_i = 4'b1000;
            tick(1);
            bus.req_i = 4'b0000;
            tick(1);
        end
        check("t4_drop2", 32'(bus.drop_count_o), 32'd2);
        bus.req_i      = 4'b1000;
        bus.clr_drop_i = 1'b1;
        tick(1);
        check("t4_clr_wins", 32'(bus.drop_count_o), 32'd0);
        bus.req_i      = 4'b0000;
        bus.clr_drop_i = 1'b0;
        tick(1);
        for (int k = 0; k < 16400; k++) begin
            bus.req_i = 4'b1111;
            tick(1);
            bus.req_i = 4'b0000;
            tick(1);
        end
        check("t4_sat", 32'(bus.drop_count_o), 32'hFFFF);
        bus.req_i = 4'b0010;
        tick(1);
        bus.req_i = 4'b0000;
        check("t4_sat_hold", 32'(bus.drop_count_o), 32'hFFFF);
        bus.clr_drop_i = 1'b1;
        tick(1);
        bus.clr_drop_i = 1'b0;
        check("t4_clr", 32'(bus.drop_count_o), 32'd0);
        bus.dead_i = 1'b0;
        tick(20);
        check("t4_drained", 32'(bus.pending_o), 32'd0);

        // Disable clears pending; one drop left in the counter for the reset test.
        bus.dead_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.req_i = 4'b0010;
            tick(1);
            bus.req_i = 4'b0000;
            tick(1);
        end
        check("t5_pending", 32'(bus.pending_o), 32'h2);
        check("t5_drop1",   32'(bus.drop_count_o), 32'd1);
        bus.src_en_i = 4'b1101;
        tick(1);
        check("t5_disabled", 32'(bus.pending_o), 32'd0);
        bus.dead_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("t5_nogrant", 32'(bus.grant_o), 32'd0);
        end
        bus.src_en_i = 4'b1111;

        // Reset in HOLDOFF with the counter at 3.
        bus.holdoff_i = 8'd5;
        tick(2);
        bus.req_i = 4'b0011;
        tick(1);
        bus.req_i = 4'b0000;
        tick(1);
        check("t6_grant",   32'(bus.grant_src_o), 32'h1);
        check("t6_pending", 32'(bus.pending_o), 32'h2);
        tick(2);
        check("t6_busy", 32'(bus.busy_o), 32'd1);
        rst_n = 1'b0;
        tick(1);
        check("t6_rst_grant",   32'(bus.grant_o), 32'd0);
        check("t6_rst_src",     32'(bus.grant_src_o), 32'd0);
        check("t6_rst_pending", 32'(bus.pending_o), 32'd0);
        check("t6_rst_busy",    32'(bus.busy_o), 32'd0);
        check("t6_rst_drop",    32'(bus.drop_count_o), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("t6_no_regrant", 32'(bus.grant_o), 32'd0);
        end
        bus.req_i = 4'b0010;
        tick(1);
        bus.req_i = 4'b0000;
        tick(1);
        check("t6_reedge_grant", 32'(bus.grant_o), 32'd1);
        check("t6_reedge_src",   32'(bus.grant_src_o), 32'h2);
        tick(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
